serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_fa_cell.sv | 16 +
 rtl/serial_adder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

    // Controller states: waiting, shifting bits, presenting the result.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit-index counter width; a one-bit datapath still needs a one-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder: the only arithmetic element in the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cy
);

    // Sum is the parity of the inputs; carry is their majority.
    always_comb begin
        s  = a ^ b ^ c;
        cy = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a
// single full-adder cell with a registered carry.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    // Index of the bit just below the MSB; unused when WIDTH is 1.
    localparam logic [CW-1:0] PRE_MSB_IDX = CW'((WIDTH > 1) ? WIDTH - 2 : 0);

    state_t           state, state_next;
    logic             accept;
    logic             last_bit;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic             carry;
    logic             carry_msb;
    logic             fa_s, fa_cy;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic and start acceptance (start only matters in IDLE/DONE).
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a
        // variable unassigned and infers a latch.
        state_next = state;
        accept     = 1'b0;
        last_bit   = (cnt == LAST_IDX);
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_bit) state_next = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    fa_cell u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .c  (carry),
        .s  (fa_s),
        .cy (fa_cy)
    );

    // Result shift register fills from the MSB so the LSB lands at bit 0.
    always_comb begin
        shreg_next            = shreg >> 1;
        shreg_next[WIDTH-1]   = fa_s;
    end

    // Operand shifters, carry, bit counter and carry-into-MSB capture.
    always_ff @(posedge clk) begin
        // NOTE: every datapath register is reset, including the shift
        // registers; the design is small enough that a clean scan/fault
        // start state is worth more than the reset fan-out.
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            shreg     <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B and force the carry-in.
            op_a      <= a;
            op_b      <= b ^ {WIDTH{sub}};
            carry     <= sub | cin;
            // For WIDTH=1 the carry into the MSB is the initial carry itself.
            carry_msb <= sub | cin;
            cnt       <= '0;
        end else if (state == S_RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= fa_cy;
            shreg <= shreg_next;
            if (!last_bit) cnt <= cnt + CW'(1);
            if ((WIDTH > 1) && (cnt == PRE_MSB_IDX)) carry_msb <= fa_cy;
        end
    end

    // Result registers load while leaving DONE; done pulses for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                sum  <= shreg;
                cout <= carry;
                ovf  <= carry_msb ^ carry;
            end
        end
    end

    assign busy = (state == S_RUN);

endmodule
